// File: rtl/pito_test_monitor.sv
// pito_test_monitor: multi-hart end-of-test monitor snooping tohost writes beside rv32_core.
// Define PITO_MON_STALL_EN to add per-hart retire-gap (stall) detection.
module pito_test_monitor #(
  parameter int unsigned NUM_HARTS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned STALL_CYCLES   = 1024,
  localparam int unsigned HW            = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tohost_valid,
  input  logic [HW-1:0]        tohost_hart,
  input  logic [31:0]          tohost_data,
  input  logic [HW-1:0]        rd_hart,
`ifdef PITO_MON_STALL_EN
  input  logic [NUM_HARTS-1:0] hart_retire,
  output logic [NUM_HARTS-1:0] hart_stall,
`endif
  output logic [CNT_W-1:0]     rd_cycles,
  output logic [30:0]          rd_code,
  output logic [NUM_HARTS-1:0] hart_done,
  output logic [NUM_HARTS-1:0] hart_pass,
  output logic                 all_done,
  output logic                 all_pass,
  output logic                 timeout,
  output logic                 busy
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  if (NUM_HARTS < 1 || NUM_HARTS > 16 || TIMEOUT_CYCLES < 1 || CNT_W < 1 ||
      STALL_CYCLES < 1) begin : g_bad_params
    $error("pito_test_monitor: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone, StTimeout} state_e;

  state_e               state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [NUM_HARTS-1:0] done_q, done_d, pass_q, pass_d;
  logic [30:0]          code_q [NUM_HARTS];
  logic [30:0]          code_d [NUM_HARTS];
  logic [CNT_W-1:0]     cnt_q  [NUM_HARTS];
  logic [CNT_W-1:0]     cnt_d  [NUM_HARTS];
  logic [NUM_HARTS-1:0] wr_hit, stall_hit;
  logic                 running, clear;
  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign running = (state_q == StRun);
  assign clear   = start && (state_q != StRun);

  always_comb begin
    wr_hit = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      wr_hit[h] = running && tohost_valid && tohost_data[0] &&
                  (32'(tohost_hart) == h) && !done_q[h];
    end
  end

`ifdef PITO_MON_STALL_EN
  localparam int unsigned GAP_W = $clog2(STALL_CYCLES + 1);

  logic [GAP_W-1:0]     gap_q [NUM_HARTS];
  logic [GAP_W-1:0]     gap_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] stall_q, stall_d;

  always_comb begin
    gap_d     = gap_q;
    stall_d   = stall_q;
    stall_hit = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (clear) begin
        gap_d[h]   = '0;
        stall_d[h] = 1'b0;
      end else if (running && !done_q[h]) begin
        if (hart_retire[h]) begin
          gap_d[h] = '0;
        end else if (gap_q[h] == GAP_W'(STALL_CYCLES - 1)) begin
          // A tohost termination in the same cycle takes precedence.
          stall_hit[h] = !wr_hit[h];
          stall_d[h]   = !wr_hit[h];
        end else begin
          gap_d[h] = gap_q[h] + GAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      stall_q <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) gap_q[h] <= '0;
    end else begin
      stall_q <= stall_d;
      gap_q   <= gap_d;
    end
  end

  assign hart_stall = stall_q;
`else
  assign stall_hit = '0;
`endif

  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    code_d = code_q;
    cnt_d  = cnt_q;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (clear) begin
        done_d[h] = 1'b0;
        pass_d[h] = 1'b0;
        code_d[h] = '0;
        cnt_d[h]  = '0;
      end else if (running && !done_q[h]) begin
        if (wr_hit[h]) begin
          done_d[h] = 1'b1;
          pass_d[h] = (tohost_data == 32'd1);
          code_d[h] = tohost_data[31:1];
        end else if (stall_hit[h]) begin
          done_d[h] = 1'b1;
          pass_d[h] = 1'b0;
          code_d[h] = '1;
        end else if (cnt_q[h] != '1) begin
          cnt_d[h] = cnt_q[h] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (start) begin
          state_d = StRun;
          wd_d    = '0;
        end
      end
      StRun: begin
        wd_d = wd_q + WD_W'(1);
        // Using done_d lets a termination on the expiry cycle win over the watchdog.
        if (&done_q) begin
          state_d = StDone;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1) && !(&done_d)) begin
          state_d = StTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      wd_q    <= '0;
      done_q  <= '0;
      pass_q  <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        code_q[h] <= '0;
        cnt_q[h]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rd_cycles = '0;
    rd_code   = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (32'(rd_hart) == h) begin
        rd_cycles = cnt_q[h];
        rd_code   = code_q[h];
      end
    end
  end

  assign hart_done = done_q;
  assign hart_pass = pass_q;
  assign busy      = (state_q == StRun);
  assign all_done  = (state_q == StDone);
  assign all_pass  = (state_q == StDone) && (&pass_q);
  assign timeout   = (state_q == StTimeout);

endmodule

// File: tb/tb_pito_test_monitor.sv
// Directed, table-driven bench for pito_test_monitor (8-hart main instance, 3-hart small instance).
module tb_pito_test_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, tv;
  logic [2:0]  th, rh;
  logic [31:0] td;
  logic [31:0] rd_cycles;
  logic [30:0] rd_code;
  logic [7:0]  hart_done, hart_pass;
  logic        all_done, all_pass, timeout, busy;

  logic        s_start, s_tv;
  logic [1:0]  s_th, s_rh;
  logic [31:0] s_td;
  logic [3:0]  s_rd_cycles;
  logic [30:0] s_rd_code;
  logic [2:0]  s_hart_done, s_hart_pass;
  logic        s_all_done, s_all_pass, s_timeout, s_busy;

`ifdef PITO_MON_STALL_EN
  logic [7:0] retire, stall;
  logic [2:0] s_retire, s_stall;
`endif

  pito_test_monitor #(
    .NUM_HARTS(8), .TIMEOUT_CYCLES(200), .CNT_W(32), .STALL_CYCLES(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tohost_valid(tv), .tohost_hart(th),
    .tohost_data(td), .rd_hart(rh),
`ifdef PITO_MON_STALL_EN
    .hart_retire(retire), .hart_stall(stall),
`endif
    .rd_cycles(rd_cycles), .rd_code(rd_code), .hart_done(hart_done), .hart_pass(hart_pass),
    .all_done(all_done), .all_pass(all_pass), .timeout(timeout), .busy(busy)
  );

  pito_test_monitor #(
    .NUM_HARTS(3), .TIMEOUT_CYCLES(40), .CNT_W(4), .STALL_CYCLES(16)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .tohost_valid(s_tv), .tohost_hart(s_th),
    .tohost_data(s_td), .rd_hart(s_rh),
`ifdef PITO_MON_STALL_EN
    .hart_retire(s_retire), .hart_stall(s_stall),
`endif
    .rd_cycles(s_rd_cycles), .rd_code(s_rd_code), .hart_done(s_hart_done),
    .hart_pass(s_hart_pass), .all_done(s_all_done), .all_pass(s_all_pass),
    .timeout(s_timeout), .busy(s_busy)
  );

  typedef struct {
    int          cyc;
    bit          st;
    logic [2:0]  hart;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int          phase;
    logic [2:0]  hart;
    logic [31:0] cyc;
    logic [30:0] code;
  } rdv_t;

  typedef struct {
    int         phase;
    logic [7:0] done;
    logic [7:0] pass;
    bit         ad, ap, to, bz;
  } stv_t;

  ev_t  sched[$];
  rdv_t rtab[$];
  stv_t stab[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives RUN cycles from..to-1 using the event schedule; ends sampling cycle 'to'.
  task automatic run(input int from, input int to);
    for (int c = from; c < to; c++) begin
      start = 1'b0; tv = 1'b0; th = 3'd0; td = 32'd0;
      foreach (sched[i]) begin
        if (sched[i].cyc == c) begin
          if (sched[i].st) start = 1'b1;
          else begin
            tv = 1'b1; th = sched[i].hart; td = sched[i].data;
          end
        end
      end
      step();
    end
    start = 1'b0; tv = 1'b0;
  endtask

  task automatic check_rd(input int p);
    foreach (rtab[i]) begin
      if (rtab[i].phase == p) begin
        rh = rtab[i].hart;
        #1;
        chk($sformatf("p%0d rd_cycles h%0d", p, rtab[i].hart), 64'(rd_cycles), 64'(rtab[i].cyc));
        chk($sformatf("p%0d rd_code h%0d", p, rtab[i].hart), 64'(rd_code), 64'(rtab[i].code));
      end
    end
  endtask

  task automatic check_st(input int p);
    foreach (stab[i]) begin
      if (stab[i].phase == p) begin
        chk($sformatf("p%0d hart_done", p), 64'(hart_done), 64'(stab[i].done));
        chk($sformatf("p%0d hart_pass", p), 64'(hart_pass), 64'(stab[i].pass));
        chk($sformatf("p%0d all_done", p), 64'(all_done), 64'(stab[i].ad));
        chk($sformatf("p%0d all_pass", p), 64'(all_pass), 64'(stab[i].ap));
        chk($sformatf("p%0d timeout", p), 64'(timeout), 64'(stab[i].to));
        chk($sformatf("p%0d busy", p), 64'(busy), 64'(stab[i].bz));
      end
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    start = 1'b0; tv = 1'b0; th = 3'd0; td = 32'd0; rh = 3'd0;
    s_start = 1'b0; s_tv = 1'b0; s_th = 2'd0; s_td = 32'd0; s_rh = 2'd0;
`ifdef PITO_MON_STALL_EN
    retire = 8'hFF; s_retire = 3'b111;
`endif

    for (int h = 0; h < 8; h++) begin
      rtab.push_back('{1, 3'(h), 32'(100 + 10 * h), 31'd0});
      rtab.push_back('{2, 3'(h), 32'(100 + 10 * h), (h == 5) ? 31'd3 : 31'd0});
      rtab.push_back('{3, 3'(h), (h == 7) ? 32'd200 : 32'(100 + 10 * h), 31'd0});
      rtab.push_back('{4, 3'(h), (h == 7) ? 32'd199 : 32'(100 + 10 * h), 31'd0});
    end
    stab.push_back('{1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0});
    stab.push_back('{2, 8'hFF, 8'hDF, 1'b1, 1'b0, 1'b0, 1'b0});
    stab.push_back('{3, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0});
    stab.push_back('{4, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0});

    // Reset state
    repeat (3) step();
    chk("rst hart_done", 64'(hart_done), 64'h0);
    chk("rst hart_pass", 64'(hart_pass), 64'h0);
    chk("rst flags", 64'({all_done, all_pass, timeout, busy}), 64'h0);
    chk("rst rd_cycles", 64'(rd_cycles), 64'h0);
    release_reset();
    chk("idle busy", 64'(busy), 64'h0);

    // Small instance: out-of-range hart, counter saturation, out-of-range readout
    s_start = 1'b1; step(); s_start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      s_tv = 1'b0; s_th = 2'd0; s_td = 32'd0;
      if (c == 2)  begin s_tv = 1'b1; s_th = 2'd3; s_td = 32'd1; end
      if (c == 5)  begin s_tv = 1'b1; s_th = 2'd0; s_td = 32'd1; end
      if (c == 30) begin s_tv = 1'b1; s_th = 2'd1; s_td = 32'h11; end
      step();
    end
    s_tv = 1'b0;
    chk("small timeout", 64'(s_timeout), 64'h1);
    chk("small hart_done", 64'(s_hart_done), 64'h3);
    chk("small hart_pass", 64'(s_hart_pass), 64'h1);
    s_rh = 2'd0; #1; chk("small cycles h0", 64'(s_rd_cycles), 64'd5);
    s_rh = 2'd1; #1; chk("small cycles h1 sat", 64'(s_rd_cycles), 64'd15);
    chk("small code h1", 64'(s_rd_code), 64'd8);
    s_rh = 2'd2; #1; chk("small cycles h2 sat", 64'(s_rd_cycles), 64'd15);
    s_rh = 2'd3; #1; chk("small rd oor", 64'({s_rd_cycles, s_rd_code}), 64'h0);

    // Test 1: all pass, start during RUN ignored, latency of hart_done and all_done
    sched.delete();
    for (int h = 0; h < 8; h++) sched.push_back('{100 + 10 * h, 1'b0, 3'(h), 32'd1});
    sched.push_back('{50, 1'b1, 3'd0, 32'd0});
    pulse_start();
    chk("t1 busy", 64'(busy), 64'h1);
    run(0, 100);
    chk("t1 done pre", 64'(hart_done), 64'h0);
    run(100, 101);
    chk("t1 done lat", 64'(hart_done), 64'h1);
    run(101, 171);
    chk("t1 done all", 64'(hart_done), 64'hFF);
    chk("t1 all_done lat", 64'({all_done, busy}), 64'h1);
    run(171, 172);
    chk("t1 all_done", 64'({all_done, busy}), 64'h2);
    run(172, 180);
    check_st(1);
    check_rd(1);

    // Test 2: hart 5 fails with code 3; restart from DONE clears state
    sched.delete();
    for (int h = 0; h < 8; h++)
      sched.push_back('{100 + 10 * h, 1'b0, 3'(h), (h == 5) ? 32'h7 : 32'd1});
    pulse_start();
    chk("t2 cleared", 64'({hart_done, hart_pass, all_done}), 64'h0);
    run(0, 180);
    check_st(2);
    check_rd(2);

    // Test 3: hart 7 never terminates -> watchdog at RUN cycle 200
    sched.delete();
    for (int h = 0; h < 7; h++) sched.push_back('{100 + 10 * h, 1'b0, 3'(h), 32'd1});
    sched.push_back('{205, 1'b0, 3'd7, 32'd1});
    pulse_start();
    run(0, 199);
    chk("t3 pre timeout", 64'({timeout, busy}), 64'h1);
    rh = 3'd7; #1; chk("t3 cycles h7 pre", 64'(rd_cycles), 64'd199);
    run(199, 200);
    check_st(3);
    check_rd(3);
    run(200, 230);
    check_st(3);
    check_rd(3);
    rst_n = 1'b0; #2;
    chk("t3 async timeout", 64'({timeout, busy, hart_done}), 64'h0);
    release_reset();

    // Test 4: last hart on the expiry cycle; late and console writes ignored
    sched.delete();
    for (int h = 0; h < 7; h++) sched.push_back('{100 + 10 * h, 1'b0, 3'(h), 32'd1});
    sched.push_back('{199, 1'b0, 3'd7, 32'd1});
    sched.push_back('{155, 1'b0, 3'd0, 32'h3});
    sched.push_back('{50, 1'b0, 3'd1, 32'h40});
    pulse_start();
    run(0, 200);
    chk("t4 cyc200", 64'({timeout, busy, all_done}), 64'h2);
    chk("t4 done cyc200", 64'(hart_done), 64'hFF);
    run(200, 201);
    check_st(4);
    check_rd(4);

    // Test 5: reset while DONE and mid-RUN, counters restart
    rst_n = 1'b0; #2;
    chk("t5 async all", 64'({all_done, all_pass, hart_done, hart_pass}), 64'h0);
    rh = 3'd3; #1; chk("t5 rst rd_cycles", 64'(rd_cycles), 64'h0);
    release_reset();
    sched.delete();
    sched.push_back('{20, 1'b0, 3'd0, 32'd1});
    pulse_start();
    run(0, 30);
    rh = 3'd0; #1; chk("t5 cycles h0", 64'(rd_cycles), 64'd20);
    rh = 3'd1; #1; chk("t5 cycles h1", 64'(rd_cycles), 64'd30);
    rst_n = 1'b0; #1;
    chk("t5 midrun rst", 64'({busy, hart_done}), 64'h0);
    chk("t5 midrun rd", 64'(rd_cycles), 64'h0);
    release_reset();
    sched.delete();
    pulse_start();
    run(0, 5);
    rh = 3'd1; #1; chk("t5 restart cycles", 64'(rd_cycles), 64'd5);

`ifdef PITO_MON_STALL_EN
    // Test 6: hart 2 stops retiring at RUN cycle 10
    rst_n = 1'b0; #2;
    release_reset();
    pulse_start();
    for (int c = 0; c < 25; c++) begin
      retire = (c >= 10) ? 8'hFB : 8'hFF;
      step();
    end
    chk("t6 no stall yet", 64'({stall, hart_done}), 64'h0);
    retire = 8'hFB;
    step();
    chk("t6 stall", 64'(stall), 64'h4);
    chk("t6 done", 64'(hart_done), 64'h4);
    chk("t6 pass", 64'(hart_pass), 64'h0);
    rh = 3'd2; #1;
    chk("t6 code", 64'(rd_code), 64'h7FFF_FFFF);
    chk("t6 cycles", 64'(rd_cycles), 64'd25);
    retire = 8'hFF;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pito_test_monitor.md
Name: pito_test_monitor

Overview:
- Synthesizable, multi-hart end-of-test monitor for the pito barrel core.
- Replaces the fixed simulation timeout and single pass/fail check with per-hart termination tracking, a parametrised cycle watchdog, per-hart cycle counts and sticky status.
- Sits beside rv32_core and snoops tohost-style writes.
- Usable in simulation and on FPGA.

Parameters:
- NUM_HARTS, 8, number of hardware threads monitored (1..16).
- TIMEOUT_CYCLES, 10000, global watchdog limit in clk cycles, counted from start.
- CNT_W, 32, width of the cycle counters.
- STALL_CYCLES, 1024, retire-gap limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a test run.
- tohost_valid  in  1  a write to the tohost register this cycle.
- tohost_hart  in  $clog2(NUM_HARTS)  hart issuing the write.
- tohost_data  in  32  written value.
- rd_hart  in  $clog2(NUM_HARTS)  hart selected for readout.
- rd_cycles  out  CNT_W  cycle count of the selected hart.
- rd_code  out  31  fail code of the selected hart.
- hart_done  out  NUM_HARTS  per-hart terminated flag.
- hart_pass  out  NUM_HARTS  per-hart pass flag, valid when hart_done is set.
- all_done  out  1  every hart has terminated.
- all_pass  out  1  all_done is set and every hart passed.
- timeout  out  1  watchdog expired.
- busy  out  1  FSM is in RUN.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - FSM goes to IDLE.
  - All counters, flags and codes clear to 0.
  - All outputs read 0.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE -> RUN on start. This clears all per-hart state and the watchdog in the same edge.
  - RUN -> DONE on the cycle all harts are done.
  - RUN -> TIMEOUT when the watchdog reaches TIMEOUT_CYCLES-1 and not all harts are done.
  - If completion and expiry fall on the same cycle, DONE wins.
  - DONE and TIMEOUT are sticky. They return to RUN only on a new start, with full clear.
  - start while in RUN is ignored.
- Termination decode, in RUN only, when tohost_valid=1 and tohost_data[0]=1:
  - Data equal to 1 is a pass.
  - Any other value is a fail, with code = tohost_data[31:1].
  - Writes with bit0=0 are ignored (console traffic).
  - tohost_hart >= NUM_HARTS is ignored.
  - The first termination per hart wins; later writes from a done hart do not change pass or code.
- Latency:
  - hart_done, hart_pass and rd_code update one cycle after the accepted write.
  - all_done, all_pass and busy reflect the registered FSM state one cycle after that.
- Cycle counters:
  - Each hart counter increments every RUN cycle while that hart is not done. It freezes on termination, including the termination cycle itself.
  - Counters saturate at all-ones; they do not wrap.
  - On TIMEOUT, counters of unfinished harts freeze.
- Watchdog:
  - Counts RUN cycles from 0.
  - timeout is set on entering TIMEOUT and held.
- Readout:
  - rd_cycles and rd_code are combinational muxes on rd_hart.
  - rd_hart out of range reads 0.
- Reset mid-run: everything clears immediately, and timeout and all_* drop asynchronously.

Optional Feature:
- Macro: PITO_MON_STALL_EN.
- When defined:
  - Adds input hart_retire [NUM_HARTS] (one pulse per retired instruction).
  - Adds output hart_stall [NUM_HARTS].
  - Each running, not-done hart has a gap counter that resets on retire.
  - When the gap reaches STALL_CYCLES, that hart is forced done with pass=0, code=31'h7FFF_FFFF, and hart_stall set (sticky until start or reset).
- When undefined:
  - The ports and logic are absent.
  - Harts terminate only via tohost or the watchdog.

Test Plan:
1. Reset, then start. Harts 0..7 each write tohost_data=1 at cycles 100+10*h -> hart_done=8'hFF, hart_pass=8'hFF, all_pass=1, rd_cycles(hart 3)=130, timeout=0.
2. Hart 5 writes 0x0000_0007, all others write 1 -> hart_pass=8'hDF, rd_code(5)=3, all_done=1, all_pass=0.
3. TIMEOUT_CYCLES=200; only harts 0..6 terminate -> timeout=1 at RUN cycle 200, FSM=TIMEOUT, hart_done=8'h7F, rd_cycles(7)=200 and frozen thereafter.
4. The last hart terminates on the same cycle the watchdog expires -> all_done=1, timeout=0. A second write from hart 0 with 0x3 -> pass and code unchanged. A write with data=0x40 -> ignored.
5. Assert rst_n=0 mid-RUN, then pulse start -> all outputs 0 during reset, and counters restart from 0.
6. With PITO_MON_STALL_EN and STALL_CYCLES=16, hart 2 stops retiring -> hart_stall[2]=1 after 16 cycles, hart_pass[2]=0, rd_code(2)=31'h7FFF_FFFF.
